// File: rtl/id_send_sched.sv
// id_send_sched
// -----------------------------------------------------------------------------
// Feeds AXI AW/AR transaction IDs into the bridge's ID send FIFO on the FIFO
// write-clock side. AW and AR requests are arbitrated, and the winner is held
// in a one-deep slot until the FIFO takes it. The number of IDs that have been
// pushed but not yet retired is capped. A flush sequence drains the slot and
// waits for every outstanding ID to retire before the bridge quiesces.
//
// Optional feature (compile-time macro ID_SEND_WR_PRIO_EN):
//   undefined : AW and AR ties are resolved round-robin.
//   defined   : AW wins ties. After STARVE_LIMIT consecutive AW grants made
//               while AR was waiting, the next tie goes to AR.
//
// Ports:
//   clk           single clock, shared with the FIFO write side
//   reset         synchronous, active-high
//   aw_valid/id   write ID request;  aw_ready = accepted this cycle
//   ar_valid/id   read ID request;   ar_ready = accepted this cycle
//   fifo_full     FIFO full flag
//   fifo_write_en FIFO write strobe
//   fifo_data     {dir, id}, where dir=1 is read and dir=0 is write
//   retire        one-cycle pulse: one outstanding ID has completed
//   flush_req     level; requests quiesce
//   flush_done    one-cycle pulse once drained
//   outstanding   current count of pushed-but-not-retired IDs
//   err_underflow sticky; a retire arrived while outstanding was 0
// -----------------------------------------------------------------------------
module id_send_sched #(
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 5,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                aw_valid,
  input  logic [ID_WIDTH-1:0] aw_id,
  output logic                aw_ready,
  input  logic                ar_valid,
  input  logic [ID_WIDTH-1:0] ar_id,
  output logic                ar_ready,
  input  logic                fifo_full,
  output logic                fifo_write_en,
  output logic [ID_WIDTH:0]   fifo_data,
  input  logic                retire,
  input  logic                flush_req,
  output logic                flush_done,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                err_underflow
);

  typedef enum logic [1:0] {IDLE, LOADED, DRAIN} state_t;

  state_t              state;
  logic                slot_vld;
  logic [ID_WIDTH:0]   slot_data;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic                flush_served;

  logic credit_ok, accept_ok, pick_ar, aw_gnt, ar_gnt, hs, ret_ok, flush_go;

  // Credit is judged on the registered count. As a result, a retire that
  // arrives in the same cycle cannot free a slot until the next cycle.
  assign credit_ok = out_cnt < CNT_WIDTH'(MAX_OUTSTANDING);
  assign accept_ok = !reset && credit_ok && !flush_req &&
                     (state == IDLE || (state == LOADED && !fifo_full));

`ifdef ID_SEND_WR_PRIO_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // AW normally wins a tie. AR is forced once AW has starved it long enough.
  assign pick_ar = (starve_cnt >= SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (ar_gnt)
      starve_cnt <= '0;
    else if (aw_gnt && ar_valid && starve_cnt < SW'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  logic last_ar;

  // Round-robin: on a tie, the side that did not win last time is granted.
  assign pick_ar = !last_ar;

  always_ff @(posedge clk) begin
    if (reset)
      last_ar <= 1'b1;            // AR was "last", so AW wins the first tie
    else if (hs)
      last_ar <= ar_gnt;
  end
`endif

  assign ar_gnt = accept_ok && ar_valid && (!aw_valid || pick_ar);
  assign aw_gnt = accept_ok && aw_valid && (!ar_valid || !pick_ar);
  assign hs     = aw_gnt || ar_gnt;

  assign aw_ready = aw_gnt;
  assign ar_ready = ar_gnt;

  // The push strobe comes only from registered slot state and the full flag.
  // It is gated off in the reset cycle so that a dropped entry never lands.
  assign fifo_write_en = !reset && slot_vld && !fifo_full;
  assign fifo_data     = slot_data;
  assign outstanding   = out_cnt;

  // Drain completion is decoded from registered state. It lasts exactly one
  // cycle because the FSM leaves DRAIN on the same edge.
  assign flush_done = !reset && state == DRAIN && !slot_vld && out_cnt == '0;

  // A flush_req held high after completion does not re-enter DRAIN. It needs
  // a low level before it can re-arm.
  assign flush_go = flush_req && !flush_served;

  assign ret_ok = retire && out_cnt != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      slot_vld      <= 1'b0;
      slot_data     <= '0;
      out_cnt       <= '0;
      err_underflow <= 1'b0;
      flush_served  <= 1'b0;
    end else begin
      // Slot: a new handshake refills it, even while the old entry is being
      // written. This is what allows one ID per cycle back-to-back.
      if (hs)
        slot_data <= {ar_gnt, ar_gnt ? ar_id : aw_id};
      slot_vld <= hs || (slot_vld && !fifo_write_en);

      // The count moves at handshake time, not at FIFO write time.
      // A handshake and a retire in the same cycle cancel each other out.
      if (hs && !ret_ok)
        out_cnt <= out_cnt + 1'b1;
      else if (!hs && ret_ok)
        out_cnt <= out_cnt - 1'b1;

      if (retire && out_cnt == '0)
        err_underflow <= 1'b1;

      if (!flush_req)
        flush_served <= 1'b0;
      else if (flush_done)
        flush_served <= 1'b1;

      case (state)
        DRAIN: begin
          // Draining continues even if flush_req drops in the meantime.
          if (flush_done)
            state <= IDLE;
        end
        default: begin
          if (flush_go)
            state <= DRAIN;
          else if (hs || (slot_vld && !fifo_write_en))
            state <= LOADED;
          else
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_send_sched.sv
// Self-checking bench for id_send_sched. The run has two parts: directed
// phases from the test plan, then a randomized segment. A reference model
// tracks accepted IDs, the outstanding count and flush progress, and pushes
// each expected FIFO entry into a scoreboard. A separate monitor compares
// every FIFO write (and the held slot data) against that scoreboard.
module tb_id_send_sched;
  localparam int IDW  = 8;
  localparam int MAXO = 16;
  localparam int CW   = 5;
  localparam int SL   = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           aw_valid = 1'b0, ar_valid = 1'b0;
  logic [IDW-1:0] aw_id = '0, ar_id = '0;
  logic           fifo_full = 1'b0, retire = 1'b0, flush_req = 1'b0;
  logic           aw_ready, ar_ready, fifo_write_en, flush_done, err_underflow;
  logic [IDW:0]   fifo_data;
  logic [CW-1:0]  outstanding;

  id_send_sched #(.ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW),
                  .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .aw_valid(aw_valid), .aw_id(aw_id), .aw_ready(aw_ready),
    .ar_valid(ar_valid), .ar_id(ar_id), .ar_ready(ar_ready),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en), .fifo_data(fifo_data),
    .retire(retire), .flush_req(flush_req), .flush_done(flush_done),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_out = 0;
  int           m_starve = 0;
  bit           m_pend = 0, m_last_ar = 1, m_drain = 0, m_served = 0, m_err = 0;
  bit           e_aw = 0, e_ar = 0, e_done = 0;
  logic [IDW:0] sbq[$];

  // Negedge: predict this cycle's readies and status from the model state.
  always @(negedge clk) begin
    bit acc, tie_ar;
    acc = !reset && (m_out < MAXO) && !flush_req && !m_drain &&
          (!m_pend || !fifo_full);
`ifdef ID_SEND_WR_PRIO_EN
    tie_ar = (m_starve >= SL);
`else
    tie_ar = !m_last_ar;
`endif
    e_ar   = acc && ar_valid && (!aw_valid || tie_ar);
    e_aw   = acc && aw_valid && !e_ar;
    e_done = !reset && m_drain && !m_pend && (m_out == 0);
    chk("aw_ready", aw_ready, e_aw);
    chk("ar_ready", ar_ready, e_ar);
    chk("outstanding", outstanding, m_out);
    chk("err_underflow", err_underflow, m_err);
    chk("flush_done", flush_done, e_done);
  end

  // Posedge: commit what the cycle did (inputs are still stable here).
  always @(posedge clk) begin
    bit hs, wr, rdec;
    if (reset) begin
      m_out = 0; m_starve = 0; m_pend = 0; m_last_ar = 1;
      m_drain = 0; m_served = 0; m_err = 0;
      sbq.delete();
    end else begin
      hs   = e_aw || e_ar;
      wr   = m_pend && !fifo_full;
      rdec = retire && (m_out > 0);
      if (hs) sbq.push_back(e_ar ? {1'b1, ar_id} : {1'b0, aw_id});
      if (retire && m_out == 0) m_err = 1;
      m_out  = m_out + (hs ? 1 : 0) - (rdec ? 1 : 0);
      m_pend = hs || (m_pend && !wr);
      if (e_ar) m_starve = 0;
      else if (e_aw && ar_valid && m_starve < SL) m_starve++;
      if (hs) m_last_ar = e_ar;
      if (e_done) m_drain = 0;
      else if (!m_drain && flush_req && !m_served) m_drain = 1;
      m_served = flush_req ? (m_served || e_done) : 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("fifo_write_en", fifo_write_en, !reset && sbq.size() > 0 && !fifo_full);
    if (sbq.size() > 0) begin
      chk("fifo_data", fifo_data, sbq[0]);
      if (fifo_write_en) void'(sbq.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit awv, logic [IDW-1:0] awi, bit arv, logic [IDW-1:0] ari,
                       bit full, bit ret, bit fl);
    aw_valid = awv; aw_id = awi; ar_valid = arv; ar_id = ari;
    fifo_full = full; retire = ret; flush_req = fl;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_write_en", fifo_write_en, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_flush_done", flush_done, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Both sides request continuously: round-robin (or priority pattern).
    repeat (10) drive(1, 8'h11, 1, 8'h22, 0, 0, 0);
    repeat (10) drive(0, 0, 0, 0, 0, 1, 0);

    // Single AW held behind a full FIFO for three cycles.
    drive(1, 8'h05, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Saturate at MAXO with reads, then retire once to free one credit.
    repeat (18) drive(0, 0, 1, 8'h30, 0, 0, 0);
    drive(0, 0, 1, 8'h31, 0, 1, 0);
    repeat (3) drive(0, 0, 1, 8'h32, 0, 0, 0);
    repeat (16) drive(0, 0, 0, 0, 0, 1, 0);

    // Retire at zero sets the sticky underflow flag.
    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

    // Flush with 3 outstanding and the slot loaded.
    drive(1, 8'h41, 0, 0, 0, 0, 0);
    drive(1, 8'h42, 0, 0, 0, 0, 0);
    drive(1, 8'h43, 0, 0, 0, 0, 0);
    drive(1, 8'h44, 1, 8'h55, 1, 0, 1);
    repeat (2) drive(1, 8'h44, 0, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1);
    repeat (2) drive(1, 8'h66, 1, 8'h77, 0, 0, 0);

    // Randomized traffic, with one reset mid-run.
    begin
      bit fl = 0;
      for (int i = 0; i < 3000; i++) begin
        int rr;
        rr = ((i / 400) % 2 == 0) ? 3 : 1;
        if ($urandom_range(0, 149) == 0) fl = !fl;
        if (i == 1500) begin
          reset = 1'b1;
          drive(1, 8'hAA, 1, 8'hBB, 0, 1, 0);
          drive(0, 0, 0, 0, 0, 0, 0);
          reset = 1'b0;
        end
        drive($urandom_range(0, 3) != 0, IDW'($urandom), $urandom_range(0, 3) != 0,
              IDW'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, rr) == 0, fl);
      end
    end
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
